// File: rtl/uart_pkg.sv
// Shared UART constants for the receive path.
// Latency: n/a (constants only).
// Backpressure: n/a.
package uart_pkg;

    // Byte width produced by the UART receiver controller.
    localparam int UART_DATA_W        = 8;

    // Default receive FIFO depth (entries).
    localparam int UART_RX_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W storage array: one synchronous write port, one asynchronous read port.
// Latency: a write in cycle N is readable from cycle N+1; the read is combinational.
// Backpressure: none; the caller decides when to write.
module uart_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read feeds the first-word-fall-through head.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer: captures one byte per rising edge of i_Rx_Done into a FWFT FIFO.
// Latency: a byte pushed in cycle N appears on o_Rd_Data/o_Rd_Valid in cycle N+1 (no bypass).
// Backpressure: none toward the receiver; a push into a full FIFO without a pop is dropped and flagged in o_Overrun.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W    = UART_DATA_W,
    parameter int DEPTH     = UART_RX_FIFO_DEPTH,
    parameter int AF_THRESH = 12
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_Rx_Done,
    input  logic [DATA_W-1:0]        i_Rx_Byte,
    output logic                     o_Rd_Valid,
    output logic [DATA_W-1:0]        o_Rd_Data,
    input  logic                     i_Rd_Ready,
    output logic [$clog2(DEPTH):0]   o_Count,
    output logic                     o_Full,
    output logic                     o_Empty,
    output logic                     o_Almost_Full,
    output logic                     o_Overrun,
    input  logic                     i_Overrun_Clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AF_THRESH);

    logic              done_q;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              overrun_q;

    logic              push_req;
    logic              pop;
    logic              wr_en;
    logic              overrun_set;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] mem_rdata;

    // Handshake decode: one push per done assertion; a full FIFO still accepts when the head is popped.
    always_comb begin
        full        = (count == CNT_FULL);
        empty       = (count == '0);
        push_req    = i_Rx_Done & ~done_q;
        pop         = ~empty & i_Rd_Ready;
        wr_en       = push_req & (~full | pop);
        overrun_set = push_req & full & ~pop;
    end

    // Edge register, pointers, occupancy count and sticky overrun flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q    <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun_q <= 1'b0;
        end else begin
            done_q <= i_Rx_Done;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            // A new overrun outranks a coincident clear.
            if (overrun_set) begin
                overrun_q <= 1'b1;
            end else if (i_Overrun_Clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk    (clk),
        .we     (wr_en),
        .waddr  (wr_ptr),
        .wdata  (i_Rx_Byte),
        .raddr  (rd_ptr),
        .rdata  (mem_rdata)
    );

    // Status flags and the zero-masked head word, all derived from the registered count.
    always_comb begin
        o_Count       = count;
        o_Full        = full;
        o_Empty       = empty;
        o_Almost_Full = (count >= CNT_AF);
        o_Rd_Valid    = ~empty;
        o_Rd_Data     = empty ? '0 : mem_rdata;
        o_Overrun     = overrun_q;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a randomized phase
// checked against a queue-based model of the FIFO, edge-triggered push and sticky overrun.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_uart_rx_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AF     = 12;

    logic              clk;
    logic              reset_n;
    logic              i_Rx_Done;
    logic [DATA_W-1:0] i_Rx_Byte;
    logic              o_Rd_Valid;
    logic [DATA_W-1:0] o_Rd_Data;
    logic              i_Rd_Ready;
    logic [4:0]        o_Count;
    logic              o_Full;
    logic              o_Empty;
    logic              o_Almost_Full;
    logic              o_Overrun;
    logic              i_Overrun_Clr;

    int checks = 0;
    int errors = 0;

    // Reference model state
    byte unsigned q[$];
    bit           m_done_q;
    bit           m_ovr;

    uart_rx_fifo #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_Rx_Done     (i_Rx_Done),
        .i_Rx_Byte     (i_Rx_Byte),
        .o_Rd_Valid    (o_Rd_Valid),
        .o_Rd_Data     (o_Rd_Data),
        .i_Rd_Ready    (i_Rd_Ready),
        .o_Count       (o_Count),
        .o_Full        (o_Full),
        .o_Empty       (o_Empty),
        .o_Almost_Full (o_Almost_Full),
        .o_Overrun     (o_Overrun),
        .i_Overrun_Clr (i_Overrun_Clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model.
    task automatic check_model(input string tag);
        int unsigned n;
        n = q.size();
        chk({tag, ":count"}, 32'(o_Count), n);
        chk({tag, ":empty"}, 32'(o_Empty), 32'(n == 0));
        chk({tag, ":full"},  32'(o_Full),  32'(n == DEPTH));
        chk({tag, ":af"},    32'(o_Almost_Full), 32'(n >= AF));
        chk({tag, ":valid"}, 32'(o_Rd_Valid), 32'(n != 0));
        chk({tag, ":data"},  32'(o_Rd_Data), (n != 0) ? 32'(q[0]) : 32'h0);
        chk({tag, ":ovr"},   32'(o_Overrun), 32'(m_ovr));
    endtask

    // Advance one clock and apply the same cycle to the model.
    task automatic tick();
        bit          done_s, rdy_s, clr_s, rst_s, push_req, pop, full, set_ovr;
        byte unsigned b;
        done_s = i_Rx_Done;
        rdy_s  = i_Rd_Ready;
        clr_s  = i_Overrun_Clr;
        rst_s  = (reset_n === 1'b0);
        b      = i_Rx_Byte;
        push_req = done_s && !m_done_q;
        pop      = (q.size() != 0) && rdy_s;
        full     = (q.size() == DEPTH);
        set_ovr  = push_req && full && !pop;
        @(posedge clk);
        #1;
        if (rst_s) begin
            q.delete();
            m_done_q = 1'b0;
            m_ovr    = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push_req && !set_ovr) q.push_back(b);
            if (set_ovr) m_ovr = 1'b1;
            else if (clr_s) m_ovr = 1'b0;
            m_done_q = done_s;
        end
    endtask

    // One done pulse carrying b, then a quiet cycle.
    task automatic push_byte(input logic [7:0] b, input logic rdy, input logic clr);
        i_Rx_Done     = 1'b1;
        i_Rx_Byte     = b;
        i_Rd_Ready    = rdy;
        i_Overrun_Clr = clr;
        tick();
        check_model("push");
        i_Rx_Done     = 1'b0;
        i_Rd_Ready    = 1'b0;
        i_Overrun_Clr = 1'b0;
        tick();
        check_model("idle");
    endtask

    task automatic drain_all();
        i_Rd_Ready = 1'b1;
        while (q.size() != 0) begin
            tick();
            check_model("drain");
        end
        i_Rd_Ready = 1'b0;
    endtask

    initial begin
        logic [7:0] head;
        reset_n       = 1'b0;
        i_Rx_Done     = 1'b0;
        i_Rx_Byte     = '0;
        i_Rd_Ready    = 1'b0;
        i_Overrun_Clr = 1'b0;
        m_done_q      = 1'b0;
        m_ovr         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // 1. Reset state
        chk("rst_empty", 32'(o_Empty), 1);
        chk("rst_count", 32'(o_Count), 0);
        chk("rst_valid", 32'(o_Rd_Valid), 0);
        chk("rst_data",  32'(o_Rd_Data), 32'h00);
        chk("rst_ovr",   32'(o_Overrun), 0);

        // 2. Done held high for 5 cycles yields exactly one entry
        i_Rx_Done = 1'b1;
        i_Rx_Byte = 8'hA5;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("held_count", 32'(o_Count), 1);
            chk("held_data",  32'(o_Rd_Data), 32'hA5);
        end
        i_Rx_Done = 1'b0;
        tick();
        check_model("held_end");
        drain_all();

        // 3. Order and wrap, three rounds
        for (int r = 0; r < 3; r++) begin
            for (int i = 1; i <= DEPTH; i++) begin
                push_byte(8'(i), 1'b0, 1'b0);
                if (i == AF - 1) chk("af_below", 32'(o_Almost_Full), 0);
                if (i == AF)     chk("af_at",    32'(o_Almost_Full), 1);
            end
            chk("wrap_full", 32'(o_Full), 1);
            chk("wrap_af",   32'(o_Almost_Full), 1);
            i_Rd_Ready = 1'b1;
            for (int i = 1; i <= DEPTH; i++) begin
                chk("wrap_order", 32'(o_Rd_Data), 32'(i));
                tick();
            end
            i_Rd_Ready = 1'b0;
            chk("wrap_empty", 32'(o_Empty), 1);
            check_model("wrap_end");
        end

        // 4. Full boundary
        for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom_range(0, 255)), 1'b0, 1'b0);
        head = o_Rd_Data;
        push_byte(8'h77, 1'b0, 1'b0);
        chk("ovr_set",   32'(o_Overrun), 1);
        chk("ovr_count", 32'(o_Count), 16);
        chk("ovr_head",  32'(o_Rd_Data), 32'(head));
        i_Overrun_Clr = 1'b1;
        tick();
        i_Overrun_Clr = 1'b0;
        chk("ovr_clr", 32'(o_Overrun), 0);
        push_byte(8'h88, 1'b1, 1'b0);
        chk("fullpop_count", 32'(o_Count), 16);
        chk("fullpop_ovr",   32'(o_Overrun), 0);
        push_byte(8'h99, 1'b0, 1'b1);
        chk("clr_vs_set", 32'(o_Overrun), 1);
        i_Rd_Ready = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) begin
            tick();
            check_model("full_drain");
        end
        chk("last_is_88", 32'(o_Rd_Data), 32'h88);
        tick();
        i_Rd_Ready = 1'b0;
        chk("full_drained", 32'(o_Empty), 1);
        i_Overrun_Clr = 1'b1;
        tick();
        i_Overrun_Clr = 1'b0;
        check_model("clr2");

        // 5. Reset mid-operation
        for (int i = 0; i < 7; i++) push_byte(8'($urandom_range(0, 255)), 1'b0, 1'b0);
        chk("pre_rst_count", 32'(o_Count), 7);
        reset_n = 1'b0;
        #1;
        chk("midrst_count", 32'(o_Count), 0);
        chk("midrst_empty", 32'(o_Empty), 1);
        tick();
        reset_n = 1'b1;
        check_model("post_rst");
        push_byte(8'h3C, 1'b0, 1'b0);
        chk("post_rst_head", 32'(o_Rd_Data), 32'h3C);
        drain_all();

        // 6. Push into empty with ready held high
        i_Rd_Ready = 1'b1;
        i_Rx_Done  = 1'b1;
        i_Rx_Byte  = 8'h5A;
        chk("nobypass_valid", 32'(o_Rd_Valid), 0);
        tick();
        chk("emptypush_count", 32'(o_Count), 1);
        chk("emptypush_valid", 32'(o_Rd_Valid), 1);
        chk("emptypush_data",  32'(o_Rd_Data), 32'h5A);
        i_Rx_Done = 1'b0;
        tick();
        chk("emptypush_popped", 32'(o_Count), 0);
        i_Rd_Ready = 1'b0;
        check_model("e6_end");

        // Randomized traffic: slow reader first (overruns), then fast reader
        for (int i = 0; i < 600; i++) begin
            i_Rx_Done     = ($urandom_range(0, 1) == 1);
            i_Rx_Byte     = 8'($urandom_range(0, 255));
            i_Rd_Ready    = (i < 300) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 1);
            i_Overrun_Clr = ($urandom_range(0, 7) == 0);
            tick();
            check_model("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
